apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter sharing the single APB master's system-side request port (Transfer/PSI_*) among NUM_REQ requesters. Grants one request at a time, drives the master for exactly one APB transfer, monitors the APB bus for completion, captures read data/error from the bus and returns it to the owning requester. Sits between the requester fabric and the APB master, in the same clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- PCLK  in  1  clock; one clock, all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request pending
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_write  in  NUM_REQ  1=write, 0=read
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_strb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes
- req_prot  in  NUM_REQ*3  packed protection attributes
- req_ready  out  NUM_REQ  one-hot accept; request i taken at edge where req_valid[i]&req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to owner
- rsp_rdata  out  DATA_WIDTH  captured read data (shared, qualified by rsp_valid)
- rsp_slverr  out  1  captured PSLVERR (shared, qualified by rsp_valid)
- busy  out  1  transfer owned (state BUSY or RESP)
- grant_id  out  $clog2(NUM_REQ)  index of current/last owner
- Transfer  out  1  to APB master: start/continue transfer
- PSI_ADDR, PSI_WRITE, PSI_WDATA, PSI_STRB, PSI_PROT  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8/3  latched request fields to APB master
- PSELx, PENABLE, PREADY  in  1 each  APB bus monitor
- PRDATA  in  DATA_WIDTH  APB bus read data monitor
- PSLVERR  in  1  APB bus error monitor

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req_valid, winner = first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap; req_ready[winner]=1 combinationally (all others 0). At the edge: latch winner's addr/write/wdata/strb/prot into PSI_* regs, last_grant<=winner, grant_id<=winner, go BUSY. No req_valid: stay IDLE, req_ready=0.
- BUSY: Transfer = ~done, where done = PSELx&PENABLE&PREADY (combinational, so the master sees Transfer=0 at its completion edge and returns to idle; no back-to-back). At edge with done: rsp_rdata<=PRDATA (reads only; writes load 0), rsp_slverr<=PSLVERR, go RESP. PSI_* held stable throughout BUSY.
- RESP: rsp_valid[grant_id]=1 for this one cycle, Transfer=0; go IDLE unconditionally.
- Fairness: requester granted last has lowest priority next arbitration; any continuously asserting requester served within NUM_REQ grants.
- Requester may drop req_valid before accept; no grant results. Request fields must be stable while req_valid=1 and unaccepted.

## Timing
- Reset (async, PRESETn=0): state IDLE; Transfer, req_ready, rsp_valid, rsp_rdata, rsp_slverr, busy, PSI_* all 0; grant_id 0; last_grant NUM_REQ-1 (requester 0 highest priority after reset).
- Reset mid-transfer: immediate IDLE, no rsp_valid for the in-flight request; requester must reissue.
- Accept edge T: BUSY from T+1, Transfer=1 from T+1. Completion edge C (done=1): rsp_valid at C+1 (RESP), IDLE at C+2; next accept earliest at edge ending C+2.
- Minimum occupancy: 1 IDLE cycle + BUSY (master SETUP+ACCESS+wait states) + 1 RESP cycle.
- Wait states: BUSY holds indefinitely while PREADY=0; no timeout.
- done while PSELx=1, PENABLE=0 (SETUP) is not completion.
- busy=1 exactly in BUSY and RESP.

## Test plan
- Reset, single read from req 2 addr 0x40, bus PRDATA=0xDEADBEEF, PREADY=1 first ACCESS -> req_ready[2] one cycle, PSI_ADDR=0x40, PSI_WRITE=0, rsp_valid=4'b0100 one cycle, rsp_rdata=0xDEADBEEF, rsp_slverr=0.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0,1; each rsp_valid one-hot matches grant_id.
- Write from req 1, data 0x12345678, strb 4'b0011, prot 3'b010, 3 wait states -> PSI_* stable across all BUSY cycles, Transfer drops combinationally in completion cycle, rsp_rdata=0.
- Read with PSLVERR=1 at completion -> rsp_slverr=1 with rsp_valid; next transfer response shows rsp_slverr=0 when PSLVERR=0.
- PRESETn low during wait states of a transfer from req 3 -> all outputs 0 immediately, no rsp_valid; after release req 0 wins over req 3.
- Requests 1 and 3 valid, last_grant=1 -> req 3 granted next, then req 1.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master request port.
// Latches the winner's request, tracks bus completion, returns the response.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]            req_prot,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_slverr,
    output logic                            busy,
    output logic [IDW-1:0]                  grant_id,
    output logic                            Transfer,
    output logic [ADDR_WIDTH-1:0]           PSI_ADDR,
    output logic                            PSI_WRITE,
    output logic [DATA_WIDTH-1:0]           PSI_WDATA,
    output logic [DATA_WIDTH/8-1:0]         PSI_STRB,
    output logic [2:0]                      PSI_PROT,
    input  logic                            PSELx,
    input  logic                            PENABLE,
    input  logic                            PREADY,
    input  logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            PSLVERR
);

    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] winner;
    logic           found;
    logic           done;
    int             cand;

    assign done = PSELx & PENABLE & PREADY;

    // round-robin search starting just after the last owner
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = IDW'(cand);
            end
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        Transfer  = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_d           = BUSY;
                end
            end
            BUSY: begin
                Transfer = ~done;
                if (done) state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant_id] = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // request latch on accept, response capture on completion
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_id     <= '0;
            PSI_ADDR     <= '0;
            PSI_WRITE    <= 1'b0;
            PSI_WDATA    <= '0;
            PSI_STRB     <= '0;
            PSI_PROT     <= '0;
            rsp_rdata    <= '0;
            rsp_slverr   <= 1'b0;
        end else begin
            if (state_q == IDLE && found) begin
                last_grant_q <= winner;
                grant_id     <= winner;
                PSI_ADDR     <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                PSI_WRITE    <= req_write[winner];
                PSI_WDATA    <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                PSI_STRB     <= req_strb[winner*SW +: SW];
                PSI_PROT     <= req_prot[winner*3 +: 3];
            end
            if (state_q == BUSY && done) begin
                rsp_rdata  <= PSI_WRITE ? '0 : PRDATA;
                rsp_slverr <= PSLVERR;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed checks of arbitration, APB completion
// tracking, response capture and asynchronous reset.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              PCLK;
    logic              PRESETn;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_write;
    logic [N*DW-1:0]   req_wdata;
    logic [N*DW/8-1:0] req_strb;
    logic [N*3-1:0]    req_prot;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_slverr;
    logic              busy;
    logic [1:0]        grant_id;
    logic              Transfer;
    logic [AW-1:0]     PSI_ADDR;
    logic              PSI_WRITE;
    logic [DW-1:0]     PSI_WDATA;
    logic [DW/8-1:0]   PSI_STRB;
    logic [2:0]        PSI_PROT;
    logic              PSELx;
    logic              PENABLE;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;

    logic [AW-1:0]     a_addr  [N];
    logic [DW-1:0]     a_wdata [N];
    logic [DW/8-1:0]   a_strb  [N];
    logic [2:0]        a_prot  [N];

    int n_chk  = 0;
    int n_fail = 0;

    apb_req_arbiter #(
        .NUM_REQ   (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .busy      (busy),
        .grant_id  (grant_id),
        .Transfer  (Transfer),
        .PSI_ADDR  (PSI_ADDR),
        .PSI_WRITE (PSI_WRITE),
        .PSI_WDATA (PSI_WDATA),
        .PSI_STRB  (PSI_STRB),
        .PSI_PROT  (PSI_PROT),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // pack the per-requester field tables onto the request buses
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]    = a_addr[i];
            req_wdata[i*DW +: DW]   = a_wdata[i];
            req_strb[i*4 +: 4]      = a_strb[i];
            req_prot[i*3 +: 3]      = a_prot[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic psi_chk(input int id);
        chk("psi_addr",  PSI_ADDR,          a_addr[id]);
        chk("psi_write", 32'(PSI_WRITE),    32'(req_write[id]));
        chk("psi_wdata", PSI_WDATA,         a_wdata[id]);
        chk("psi_strb",  32'(PSI_STRB),     32'(a_strb[id]));
        chk("psi_prot",  32'(PSI_PROT),     32'(a_prot[id]));
    endtask

    // one complete grant: accept, idle-to-setup, setup, waits, access, resp
    task automatic xfer(input int id, input int waits,
                        input logic [31:0] prd, input logic err,
                        input logic drop);
        logic [31:0] exp_rd;
        exp_rd = req_write[id] ? 32'h0 : prd;
        #1;
        chk("req_ready", 32'(req_ready), 32'(1 << id));
        chk("busy_idle", 32'(busy), 32'h0);
        tick();
        if (drop) req_valid[id] = 1'b0;
        #1;
        chk("busy",      32'(busy),      32'h1);
        chk("grant_id",  32'(grant_id),  32'(id));
        chk("xfer_busy", 32'(Transfer),  32'h1);
        chk("ready_off", 32'(req_ready), 32'h0);
        psi_chk(id);
        tick();
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PREADY  = 1'b1;
        #1;
        chk("xfer_setup", 32'(Transfer), 32'h1);
        tick();
        PENABLE = 1'b1;
        PREADY  = 1'b0;
        PRDATA  = ~prd;
        PSLVERR = ~err;
        for (int w = 0; w < waits; w++) begin
            #1;
            chk("xfer_wait", 32'(Transfer), 32'h1);
            psi_chk(id);
            tick();
        end
        PREADY  = 1'b1;
        PRDATA  = prd;
        PSLVERR = err;
        #1;
        chk("xfer_done", 32'(Transfer),  32'h0);
        chk("rsp_early", 32'(rsp_valid), 32'h0);
        psi_chk(id);
        tick();
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        #1;
        chk("rsp_valid",  32'(rsp_valid),  32'(1 << id));
        chk("rsp_rdata",  rsp_rdata,       exp_rd);
        chk("rsp_slverr", 32'(rsp_slverr), 32'(err));
        chk("busy_resp",  32'(busy),       32'h1);
        chk("xfer_resp",  32'(Transfer),   32'h0);
        tick();
        chk("rsp_off",    32'(rsp_valid),  32'h0);
        chk("busy_off",   32'(busy),       32'h0);
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = '0;
        req_write = 4'b0010;
        PSELx     = 1'b0;
        PENABLE   = 1'b0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        a_addr[0] = 32'h10;  a_wdata[0] = 32'h0;
        a_addr[1] = 32'h20;  a_wdata[1] = 32'h12345678;
        a_addr[2] = 32'h40;  a_wdata[2] = 32'h0;
        a_addr[3] = 32'h80;  a_wdata[3] = 32'h0;
        a_strb[0] = 4'hF;    a_prot[0]  = 3'b000;
        a_strb[1] = 4'b0011; a_prot[1]  = 3'b010;
        a_strb[2] = 4'hF;    a_prot[2]  = 3'b001;
        a_strb[3] = 4'hF;    a_prot[3]  = 3'b100;

        // reset state
        #2;
        chk("rst_transfer", 32'(Transfer),   32'h0);
        chk("rst_ready",    32'(req_ready),  32'h0);
        chk("rst_rsp",      32'(rsp_valid),  32'h0);
        chk("rst_rdata",    rsp_rdata,       32'h0);
        chk("rst_slverr",   32'(rsp_slverr), 32'h0);
        chk("rst_busy",     32'(busy),       32'h0);
        chk("rst_gid",      32'(grant_id),   32'h0);
        chk("rst_paddr",    PSI_ADDR,        32'h0);
        chk("rst_pstrb",    32'(PSI_STRB),   32'h0);
        tick();
        tick();
        PRESETn = 1'b1;
        tick();
        chk("idle_ready", 32'(req_ready), 32'h0);

        // single read from requester 2
        req_valid = 4'b0100;
        xfer(2, 0, 32'hDEADBEEF, 1'b0, 1'b1);

        // all four continuously from reset: 0,1,2,3,0,1
        PRESETn = 1'b0;
        #2;
        PRESETn = 1'b1;
        tick();
        req_valid = 4'b1111;
        xfer(0, 0, 32'h00000A00, 1'b0, 1'b0);
        xfer(1, 1, 32'h00000A01, 1'b0, 1'b0);
        xfer(2, 0, 32'h00000A02, 1'b0, 1'b0);
        xfer(3, 2, 32'h00000A03, 1'b0, 1'b0);
        xfer(0, 0, 32'h00000B00, 1'b0, 1'b0);
        xfer(1, 0, 32'h00000B01, 1'b0, 1'b0);
        req_valid = 4'b0000;

        // last_grant=1 with 1 and 3 pending: 3 first, then 1
        req_valid = 4'b1010;
        xfer(3, 0, 32'h33333333, 1'b0, 1'b1);
        xfer(1, 0, 32'h11111111, 1'b0, 1'b1);

        // write from requester 1 with three wait states
        req_valid = 4'b0010;
        xfer(1, 3, 32'hA5A5A5A5, 1'b0, 1'b1);

        // error response, then a clean one
        req_valid = 4'b0001;
        xfer(0, 1, 32'hBAD0BAD0, 1'b1, 1'b1);
        req_valid = 4'b0100;
        xfer(2, 0, 32'h00001111, 1'b0, 1'b1);

        // reset during wait states of a transfer from requester 3
        req_valid = 4'b1000;
        #1;
        chk("r3_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        tick();
        PSELx = 1'b1;
        tick();
        PENABLE = 1'b1;
        PREADY  = 1'b0;
        tick();
        tick();
        chk("r3_wait", 32'(Transfer), 32'h1);
        PRESETn = 1'b0;
        #1;
        chk("mid_transfer", 32'(Transfer),   32'h0);
        chk("mid_busy",     32'(busy),       32'h0);
        chk("mid_ready",    32'(req_ready),  32'h0);
        chk("mid_rsp",      32'(rsp_valid),  32'h0);
        chk("mid_rdata",    rsp_rdata,       32'h0);
        chk("mid_slverr",   32'(rsp_slverr), 32'h0);
        chk("mid_paddr",    PSI_ADDR,        32'h0);
        chk("mid_pprot",    32'(PSI_PROT),   32'h0);
        chk("mid_gid",      32'(grant_id),   32'h0);
        tick();
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        chk("mid_rsp2", 32'(rsp_valid), 32'h0);
        tick();
        PRESETn   = 1'b1;
        req_valid = 4'b1001;
        xfer(0, 0, 32'h0000CAFE, 1'b0, 1'b1);
        req_valid = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
